// File: rtl/spi_frame_receiver_pkg.sv
// ---------------------------------------------------------------------------
// spi_frame_receiver_pkg
//   Shared definitions for the SPI frame receiver: receiver state encoding
//   and the default word width / synchronizer depth / buffer depth. The word
//   width default is the value the SPI pattern generator uses, so both ends
//   of a loop-back agree.
// ---------------------------------------------------------------------------
package spi_frame_receiver_pkg;

  // Receiver control states (2-bit encoding).
  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,  // after reset: wait for CS high before trusting a frame
    ST_IDLE      = 2'd1,  // CS high, waiting for a frame to start
    ST_SHIFT     = 2'd2   // CS low, deserializing bits
  } rx_state_e;

  localparam int DEFAULT_WORD_W      = 16;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_FIFO_DEPTH  = 4;

  // True when v is a positive power of two.
  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/spi_frame_receiver_if.sv
// ---------------------------------------------------------------------------
// spi_frame_receiver_if
//   Valid/ready word stream leaving the SPI frame receiver.
//   Signals:
//     out_data   word being offered
//     out_valid  out_data holds a word
//     out_ready  consumer accepts; transfer when out_valid & out_ready
//   Modports:
//     master  the receiver (drives data/valid, reads ready)
//     slave   the consumer (reads data/valid, drives ready)
// ---------------------------------------------------------------------------
interface spi_frame_receiver_if
  import spi_frame_receiver_pkg::*;
#(
  parameter int WORD_W = DEFAULT_WORD_W
) ();

  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/spi_frame_receiver_rx_sync.sv
// ---------------------------------------------------------------------------
// spi_rx_sync
//   Brings the asynchronous SPI pins into the system clock domain.
//   CS and SCLK go through SYNC_STAGES-deep chains followed by an edge
//   detector; SDO is only synchronized.
//   Ports:
//     i_clk, i_rst_n   system clock, synchronous active-low reset
//     i_cs, i_sclk, i_sdo   raw SPI pins
//     o_cs_s           synchronized CS level
//     o_cs_fall/o_cs_rise   one-cycle CS edge strobes
//     o_sclk_rise      one-cycle SCLK rising-edge strobe
//     o_sdo_s          synchronized SDO, aligned with o_sclk_rise
// ---------------------------------------------------------------------------
module spi_rx_sync
  import spi_frame_receiver_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_cs,
  input  logic i_sclk,
  input  logic i_sdo,
  output logic o_cs_s,
  output logic o_sclk_rise,
  output logic o_cs_fall,
  output logic o_cs_rise,
  output logic o_sdo_s
);

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_sdo_sync;
  logic                   r_cs_prev;
  logic                   r_sclk_prev;

  // Synchronizer chains and previous-value flops for edge detection.
  // CS resets to 0 (not to its idle 1) so that a frame already in progress
  // when reset releases is never mistaken for a fresh CS fall.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cs_sync   <= '0;
      r_sclk_sync <= '0;
      r_sdo_sync  <= '0;
      r_cs_prev   <= 1'b0;
      r_sclk_prev <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_sdo_sync  <= {r_sdo_sync[SYNC_STAGES-2:0], i_sdo};
      r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
    end
  end

  assign o_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign o_sdo_s     = r_sdo_sync[SYNC_STAGES-1];
  assign o_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
  assign o_cs_fall   = ~r_cs_sync[SYNC_STAGES-1] & r_cs_prev;
  assign o_cs_rise   = r_cs_sync[SYNC_STAGES-1] & ~r_cs_prev;

endmodule

// File: rtl/spi_frame_receiver.sv
// ---------------------------------------------------------------------------
// spi_frame_receiver
//   Rebuilds a mode-0 SPI stream (CS/SCLK/SDO) into WORD_W-bit words,
//   MSB first, and offers them on a valid/ready interface. A frame may hold
//   several back-to-back words; a frame closed mid-word raises frame_err.
//   Optional macro SPI_RX_FIFO_EN: FIFO_DEPTH-entry first-word-fall-through
//   buffer; otherwise a single holding register.
//   Ports:
//     CLK_IN     system clock
//     RST_N      synchronous reset, active low
//     CS, SCLK, SDO   asynchronous SPI pins
//     out_if     word stream (master modport)
//     frame_err  1-cycle pulse: CS rose with a partial word pending
//     overrun    1-cycle pulse: completed word dropped, buffer full
//     busy       receiver is inside a frame (SHIFT)
// ---------------------------------------------------------------------------
module spi_frame_receiver
  import spi_frame_receiver_pkg::*;
#(
  parameter int WORD_W      = DEFAULT_WORD_W,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
  input  logic                 CLK_IN,
  input  logic                 RST_N,
  input  logic                 CS,
  input  logic                 SCLK,
  input  logic                 SDO,
  spi_frame_receiver_if.master out_if,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int               CNT_W    = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Illegal configurations stop elaboration.
`ifdef SPI_RX_FIFO_EN
  if (SYNC_STAGES < 2 || WORD_W < 3 || FIFO_DEPTH < 2 || !is_pow2(FIFO_DEPTH)) begin : g_bad_cfg
    $error("spi_frame_receiver: illegal parameter set");
  end
`else
  if (SYNC_STAGES < 2 || WORD_W < 3 || FIFO_DEPTH < 1) begin : g_bad_cfg
    $error("spi_frame_receiver: illegal parameter set");
  end
`endif

  logic w_cs_s, w_sclk_rise, w_cs_fall, w_cs_rise, w_sdo_s;

  spi_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk       (CLK_IN),
    .i_rst_n     (RST_N),
    .i_cs        (CS),
    .i_sclk      (SCLK),
    .i_sdo       (SDO),
    .o_cs_s      (w_cs_s),
    .o_sclk_rise (w_sclk_rise),
    .o_cs_fall   (w_cs_fall),
    .o_cs_rise   (w_cs_rise),
    .o_sdo_s     (w_sdo_s)
  );

  rx_state_e         r_state;
  rx_state_e         w_next_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  // Only WORD_W-1 bits are stored: the last bit joins them on the push.
  logic [WORD_W-2:0] r_shift;
  logic              w_take_bit;
  logic              w_word_done;
  logic              w_frame_err;
  logic              w_clear_cnt;
  logic              w_push;
  logic [WORD_W-1:0] w_push_data;
  logic              w_pop;
  logic              w_accept;
  logic              r_frame_err;
  logic              r_overrun;
  logic              r_busy;

  // State register.
  always_ff @(posedge CLK_IN) begin
    if (!RST_N) begin
      r_state <= ST_WAIT_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    w_next_state = r_state;
    w_take_bit   = 1'b0;
    w_word_done  = 1'b0;
    w_frame_err  = 1'b0;
    w_clear_cnt  = 1'b0;
    case (r_state)
      ST_WAIT_IDLE: begin
        if (w_cs_s) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_WAIT_IDLE;
        end
      end
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_next_state = ST_SHIFT;
          w_clear_cnt  = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // A bit arriving together with CS rise is taken before the close.
        if (w_sclk_rise) begin
          w_take_bit  = 1'b1;
          w_word_done = (r_bit_cnt == LAST_BIT);
        end else begin
          w_take_bit  = 1'b0;
        end
        if (w_cs_rise) begin
          w_next_state = ST_IDLE;
          w_clear_cnt  = 1'b1;
          w_frame_err  = !w_word_done && ((r_bit_cnt != CNT_ZERO) || w_sclk_rise);
        end else begin
          w_next_state = ST_SHIFT;
        end
      end
      default: begin
        w_next_state = ST_WAIT_IDLE;
      end
    endcase
  end

  // Deserializer: shift register and bit counter. The completing bit is
  // pushed straight into the buffer, so the counter never reaches WORD_W.
  always_ff @(posedge CLK_IN) begin
    if (!RST_N) begin
      r_shift   <= '0;
      r_bit_cnt <= CNT_ZERO;
    end else if (w_clear_cnt || w_word_done) begin
      r_shift   <= '0;
      r_bit_cnt <= CNT_ZERO;
    end else if (w_take_bit) begin
      r_shift   <= {r_shift[WORD_W-3:0], w_sdo_s};
      r_bit_cnt <= r_bit_cnt + CNT_ONE;
    end else begin
      r_shift   <= r_shift;
      r_bit_cnt <= r_bit_cnt;
    end
  end

  assign w_push      = w_word_done;
  assign w_push_data = {r_shift, w_sdo_s};

`ifdef SPI_RX_FIFO_EN
  localparam int             AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_empty;
  logic              w_full;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop    = ~w_empty & out_if.out_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign w_accept = w_push & (~w_full | w_pop);

  // FIFO storage and pointers.
  always_ff @(posedge CLK_IN) begin
    if (!RST_N) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr[AW-1:0]] <= w_push_data;
        r_wr_ptr                <= r_wr_ptr + PTR_ONE;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

  assign out_if.out_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign out_if.out_valid = ~w_empty;
`else
  logic [WORD_W-1:0] r_hold_data;
  logic              r_hold_valid;

  assign w_pop    = r_hold_valid & out_if.out_ready;
  assign w_accept = w_push & (~r_hold_valid | w_pop);

  // Single-entry holding register.
  always_ff @(posedge CLK_IN) begin
    if (!RST_N) begin
      r_hold_data  <= '0;
      r_hold_valid <= 1'b0;
    end else if (w_accept) begin
      r_hold_data  <= w_push_data;
      r_hold_valid <= 1'b1;
    end else if (w_pop) begin
      r_hold_data  <= r_hold_data;
      r_hold_valid <= 1'b0;
    end else begin
      r_hold_data  <= r_hold_data;
      r_hold_valid <= r_hold_valid;
    end
  end

  assign out_if.out_data  = r_hold_data;
  assign out_if.out_valid = r_hold_valid;
`endif

  // Status pulses and busy flag.
  always_ff @(posedge CLK_IN) begin
    if (!RST_N) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      r_overrun   <= w_push & ~w_accept;
      r_busy      <= (w_next_state == ST_SHIFT);
    end
  end

  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = r_busy;

endmodule
